// File: rtl/adbg_jsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adbg_jsp_pkg
// Description : Shared sizes and types for the JTAG serial port FIFOs and core.
// Revision    : 1.0 - initial release
// ============================================================================
package adbg_jsp_pkg;

  localparam int JSP_FIFO_DEPTH = 8;
  localparam int JSP_CNT_W      = 4;

  typedef logic [7:0]           jsp_byte_t;
  typedef logic [JSP_CNT_W-1:0] jsp_cnt_t;

endpackage : adbg_jsp_pkg
`default_nettype wire

// File: rtl/adbg_jsp_txfifo.sv
`default_nettype none
// ============================================================================
// Module      : adbg_jsp_txfifo
// Description : Wishbone-side byte FIFO of the JTAG serial port with registered
//               occupancy/free counts for the TCK-domain synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module adbg_jsp_txfifo
  import adbg_jsp_pkg::*;
#(
  parameter int DEPTH = JSP_FIFO_DEPTH,
  parameter int DW    = 8,
  parameter int CW    = JSP_CNT_W
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          CLR,
  input  logic [DW-1:0] DATA_IN,
  input  logic          PUSH,
  input  logic          POP,
  output logic [DW-1:0] DATA_OUT,
  output logic [CW-1:0] BYTES_AVAIL,
  output logic [CW-1:0] BYTES_FREE,
  output logic          EMPTY,
  output logic          FULL,
  output logic          OVF,
  output logic          UDF
);

  localparam int            c_AW        = $clog2(DEPTH);
  localparam logic [CW-1:0] c_DEPTH_CNT = CW'(DEPTH);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [c_AW-1:0] r_wp;
  logic [c_AW-1:0] r_rp;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_free;
  logic            r_empty;
  logic            r_full;
  logic            r_ovf;
  logic            r_udf;

  logic            w_push_ok;
  logic            w_pop_ok;
  logic            w_ovf_set;
  logic            w_udf_set;
  logic [CW-1:0]   w_cnt_nxt;

  // A full FIFO still takes a push when the head is leaving in the same cycle.
  assign w_push_ok = PUSH && (!r_full || POP);
  assign w_pop_ok  = POP && !r_empty;
  assign w_ovf_set = PUSH && r_full && !POP;
  assign w_udf_set = POP && r_empty;

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_cnt_nxt = r_cnt + CW'(1);
      2'b01:   w_cnt_nxt = r_cnt - CW'(1);
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RSTN && !CLR && w_push_ok) begin
      r_mem[r_wp] <= DATA_IN;
    end
  end

  // All count/flag outputs load from w_cnt_nxt on the same edge so the
  // downstream synchronizer never samples a mixed old/new value.
  always_ff @(posedge CLK) begin
    if (!RSTN || CLR) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_free  <= c_DEPTH_CNT;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wp <= r_wp + c_AW'(1);
      end
      if (w_pop_ok) begin
        r_rp <= r_rp + c_AW'(1);
      end
      r_cnt   <= w_cnt_nxt;
      r_free  <= c_DEPTH_CNT - w_cnt_nxt;
      r_empty <= (w_cnt_nxt == '0);
      r_full  <= (w_cnt_nxt == c_DEPTH_CNT);
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end
      if (w_udf_set) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign DATA_OUT    = r_empty ? '0 : r_mem[r_rp];
  assign BYTES_AVAIL = r_cnt;
  assign BYTES_FREE  = r_free;
  assign EMPTY       = r_empty;
  assign FULL        = r_full;
  assign OVF         = r_ovf;
  assign UDF         = r_udf;

endmodule : adbg_jsp_txfifo
`default_nettype wire

// File: tb/tb_adbg_jsp_txfifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_adbg_jsp_txfifo
// Description : Directed vector table plus reference-model random run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adbg_jsp_txfifo;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       CLR = 1'b0;
  logic       PUSH = 1'b0;
  logic       POP = 1'b0;
  logic [7:0] DATA_IN = 8'h00;
  logic [7:0] DATA_OUT;
  logic [3:0] BYTES_AVAIL;
  logic [3:0] BYTES_FREE;
  logic       EMPTY;
  logic       FULL;
  logic       OVF;
  logic       UDF;

  int checks = 0;
  int errors = 0;

  adbg_jsp_txfifo #(.DEPTH(8), .DW(8), .CW(4)) dut (
    .CLK(CLK), .RSTN(RSTN), .CLR(CLR), .DATA_IN(DATA_IN), .PUSH(PUSH),
    .POP(POP), .DATA_OUT(DATA_OUT), .BYTES_AVAIL(BYTES_AVAIL),
    .BYTES_FREE(BYTES_FREE), .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF), .UDF(UDF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rstn;
    logic       clr;
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [3:0] avail;
    logic       ovf;
    logic       udf;
    logic [7:0] dout;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic add(input logic rstn, input logic clr, input logic push,
                     input logic pop, input logic [7:0] din, input logic [3:0] av,
                     input logic ovf, input logic udf, input logic [7:0] dout);
    vec_t v;
    v.rstn = rstn; v.clr = clr; v.push = push; v.pop = pop; v.din = din;
    v.avail = av; v.ovf = ovf; v.udf = udf; v.dout = dout;
    tbl.push_back(v);
  endtask

  task automatic check_all(input int idx, input logic [3:0] av, input logic ovf,
                           input logic udf, input logic [7:0] dout);
    chk("avail", idx, 32'(BYTES_AVAIL), 32'(av));
    chk("free",  idx, 32'(BYTES_FREE),  32'(4'd8 - av));
    chk("empty", idx, 32'(EMPTY),       32'(av == 4'd0));
    chk("full",  idx, 32'(FULL),        32'(av == 4'd8));
    chk("ovf",   idx, 32'(OVF),         32'(ovf));
    chk("udf",   idx, 32'(UDF),         32'(udf));
    chk("dout",  idx, 32'(DATA_OUT),    32'(dout));
  endtask

  initial begin
    logic [7:0] drain2 [8];
    logic [7:0] q[$];
    logic       movf;
    logic       mudf;
    logic       pa;
    logic       pp;
    logic [3:0] prev_av;
    int         bias;

    // Reset, then fill 01..08 and overflow with AA
    add(0,0,0,0,8'h00, 4'd0,0,0,8'h00);
    add(0,0,0,0,8'h00, 4'd0,0,0,8'h00);
    add(1,0,0,0,8'h00, 4'd0,0,0,8'h00);
    for (int k = 1; k <= 8; k++) add(1,0,1,0,8'(k), 4'(k),0,0,8'h01);
    add(1,0,1,0,8'hAA, 4'd8,1,0,8'h01);
    for (int j = 1; j <= 8; j++) add(1,0,0,1,8'h00, 4'(8-j),1,0, (j < 8) ? 8'(j+1) : 8'h00);
    add(1,0,0,1,8'h00, 4'd0,1,1,8'h00);
    add(1,0,0,0,8'h00, 4'd0,1,1,8'h00);
    add(1,1,0,0,8'h00, 4'd0,0,0,8'h00);
    // Simultaneous push/pop at count 3, refill across the pointer wrap
    add(1,0,1,0,8'h21, 4'd1,0,0,8'h21);
    add(1,0,1,0,8'h22, 4'd2,0,0,8'h21);
    add(1,0,1,0,8'h23, 4'd3,0,0,8'h21);
    add(1,0,1,1,8'h24, 4'd3,0,0,8'h22);
    for (int k = 0; k < 5; k++) add(1,0,1,0,8'h11 + 8'(k), 4'(4+k),0,0,8'h22);
    add(1,0,1,1,8'h55, 4'd8,0,0,8'h23);
    drain2 = '{8'h24, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h55, 8'h00};
    for (int j = 0; j < 8; j++) add(1,0,0,1,8'h00, 4'(7-j),0,0,drain2[j]);
    // Empty push+pop, then flush and reset mid-stream
    add(1,0,1,1,8'h77, 4'd1,0,1,8'h77);
    for (int k = 1; k <= 4; k++) add(1,0,1,0,8'(k), 4'(1+k),0,1,8'h77);
    add(1,1,1,0,8'hEE, 4'd0,0,0,8'h00);
    for (int k = 0; k < 4; k++) add(1,0,1,0,8'hA1 + 8'(k), 4'(1+k),0,0,8'hA1);
    add(0,0,1,0,8'hEE, 4'd0,0,0,8'h00);
    add(1,0,1,0,8'h5A, 4'd1,0,0,8'h5A);

    #1;
    foreach (tbl[i]) begin
      RSTN = tbl[i].rstn; CLR = tbl[i].clr; PUSH = tbl[i].push;
      POP = tbl[i].pop; DATA_IN = tbl[i].din;
      @(posedge CLK); #1;
      check_all(i, tbl[i].avail, tbl[i].ovf, tbl[i].udf, tbl[i].dout);
    end

    // Random run against a queue model, starting from a flush
    RSTN = 1'b1; CLR = 1'b1; PUSH = 1'b0; POP = 1'b0;
    @(posedge CLK); #1;
    CLR = 1'b0;
    q.delete(); movf = 1'b0; mudf = 1'b0; bias = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 200 == 0) bias = $urandom_range(20, 80);
      PUSH = ($urandom_range(0, 99) < bias);
      POP  = ($urandom_range(0, 99) < (100 - bias));
      CLR  = ($urandom_range(0, 499) == 0);
      DATA_IN = 8'($urandom);
      prev_av = BYTES_AVAIL;
      if (CLR) begin
        q.delete(); movf = 1'b0; mudf = 1'b0;
      end else begin
        pp = POP && (q.size() > 0);
        pa = PUSH && ((q.size() < 8) || POP);
        if (PUSH && !POP && q.size() == 8) movf = 1'b1;
        if (POP && q.size() == 0) mudf = 1'b1;
        if (pp) void'(q.pop_front());
        if (pa) q.push_back(DATA_IN);
      end
      @(posedge CLK); #1;
      check_all(100000 + c, 4'(q.size()), movf, mudf, (q.size() > 0) ? q[0] : 8'h00);
      chk("sum", c, 32'(BYTES_AVAIL + BYTES_FREE), 32'd8);
      if (!CLR) begin
        chk("step", c, 32'((BYTES_AVAIL > prev_av) ? (BYTES_AVAIL - prev_av)
                                                  : (prev_av - BYTES_AVAIL)) <= 32'd1, 32'd1);
      end
    end
    CLR = 1'b0; PUSH = 1'b0; POP = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_adbg_jsp_txfifo
`default_nettype wire
